// File: rtl/sel_sequencer.sv
// Input FIFO feeding a four-phase select sequencer: each queued sample is presented on `a`
// while {sel,sel_1} steps through LOAD/SHIFT/HOLD/FLUSH, STEP_CYCLES cycles per phase.
module sel_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [3:0]               din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [3:0]               a,
    output logic                     sel,
    output logic                     sel_1,
    output logic                     busy,
    output logic                     seq_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [3:0] LastPhase = 4'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StHold, StFlush} state_e;

    state_e          state_q, state_d;
    logic [3:0]      phase_q, phase_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      a_q;
    logic            sel_q, sel_d, sel1_q, sel1_d;
    logic [3:0]      mem_q [DEPTH];
    logic            push, pop, phase_last;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pop        = 1'b0;
        phase_last = (phase_q == LastPhase);
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                    phase_d = '0;
                end
            end
            StLoad, StShift, StHold: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = (state_q == StLoad)  ? StShift :
                              (state_q == StShift) ? StHold  : StFlush;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StFlush: begin
                if (phase_last) begin
                    phase_d = '0;
                    // Chain straight into the next sample with no idle bubble.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase

        din_ready = (count_q != CW'(DEPTH)) && !clear;
        push      = din_valid && din_ready;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        sel_d  = (state_d == StShift) || (state_d == StFlush);
        sel1_d = (state_d == StHold)  || (state_d == StFlush);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= '0;
            sel_q    <= 1'b0;
            sel1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            sel1_q  <= sel1_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                a_q      <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: clearing the pointers and count discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign a          = a_q;
    assign sel        = sel_q;
    assign sel_1      = sel1_q;
    assign busy       = (state_q != StIdle);
    assign seq_done   = (state_q == StFlush) && phase_last;
    assign fifo_count = count_q;

endmodule

// File: doc/sel_sequencer.md
SEL_SEQUENCER -- requirements
Module: sel_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, input FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter STEP_CYCLES, default 1, clock cycles each select phase lasts (1..15).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have clear  input  1  synchronous, active-high reset; priority over all other inputs.
REQ-005 SHALL have din  input  4  sample from producer.
REQ-006 SHALL have din_valid  input  1  din holds a valid sample this cycle.
REQ-007 SHALL have din_ready  output  1  FIFO can accept a sample this cycle.
REQ-008 SHALL have a  output  4  registered sample to the downstream delay stage.
REQ-009 SHALL have sel  output  1  registered phase select bit 0 to the delay stage.
REQ-010 SHALL have sel_1  output  1  registered phase select bit 1 to the delay stage.
REQ-011 SHALL have busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have seq_done  output  1  one-cycle pulse on the final cycle of a sample's sequence.
REQ-013 SHALL have fifo_count  output  clog2(DEPTH)+1  number of queued samples.

Function
REQ-014 SHALL push din when din_valid && din_ready on a rising edge; din_ready = (fifo_count != DEPTH) && !clear.
REQ-015 SHALL keep FIFO strictly in order; no sample dropped or duplicated.
REQ-016 SHALL implement FSM states IDLE, LOAD, SHIFT, HOLD, FLUSH; {sel,sel_1} = 00 in IDLE/LOAD, 10 in SHIFT, 01 in HOLD, 11 in FLUSH.
REQ-017 SHALL, in IDLE with fifo_count != 0, pop head into a and enter LOAD on the same edge.
REQ-018 SHALL advance LOAD->SHIFT->HOLD->FLUSH after exactly STEP_CYCLES cycles per state, tracked by a phase counter reset on each transition.
REQ-019 SHALL, at end of FLUSH, pop next sample directly into LOAD if fifo_count != 0 (no IDLE bubble), else go IDLE.
REQ-020 SHALL hold a constant from LOAD through FLUSH; in IDLE a SHALL retain last presented value.
REQ-021 SHALL assert seq_done only during the last cycle of FLUSH.
REQ-022 SHALL, on simultaneous push and pop, leave fifo_count unchanged and push to the tail.
REQ-023 SHALL present a sample accepted on edge E into empty FIFO with FSM IDLE as a, with {sel,sel_1}=00, after edge E+1 (fifo_count=1 between E and E+1).
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-025 SHALL, on any edge with clear=1, set a=0, sel=0, sel_1=0, busy=0, seq_done=0, fifo_count=0, FSM=IDLE, phase counter=0.
REQ-026 SHALL discard queued samples and abort any in-progress sequence on clear, including mid-phase.
REQ-027 SHALL ignore din_valid during clear; din_ready=0 while clear=1, 1 the cycle after release.

Verification
REQ-028 SHALL cover: clear high 2 cycles -> a=0, sel=0, sel_1=0, busy=0, fifo_count=0; din_ready=1 after release.
REQ-029 SHALL cover: push 4 at edge E (STEP_CYCLES=1) -> after E+1 a=4,{sel,sel_1}=00; E+2 10; E+3 01; E+4 11 with seq_done=1; E+5 00, busy=0.
REQ-030 SHALL cover: back-to-back push 4 then 1 -> after 4's FLUSH, a=1 with 00 on the next cycle, busy stays 1, no IDLE cycle.
REQ-031 SHALL cover: continuous din_valid with 6 samples 1..6 -> din_ready low while fifo_count=4; a shows 1..6 in order, none lost.
REQ-032 SHALL cover: clear asserted in HOLD with 2 queued -> next cycle all outputs reset, fifo_count=0; subsequent push 9 sequences normally.
REQ-033 SHALL cover: STEP_CYCLES=3, push 7 -> each of LOAD/SHIFT/HOLD/FLUSH lasts 3 cycles; seq_done high only in FLUSH's third cycle.
